// File: rtl/led_ind_pkg.sv
// Shared types and constants for the LED flow indicator.
package led_ind_pkg;

    typedef enum logic [1:0] {
        JOHNSON = 2'd0,
        ROTATE  = 2'd1,
        BLINK   = 2'd2,
        BAR     = 2'd3
    } mode_t;

    localparam int unsigned MAX_LED     = 16;
    // ROTATE is the only pattern that starts from a non-zero value.
    localparam logic [MAX_LED-1:0] ROTATE_SEED = 16'h0001;

endpackage

// File: rtl/act_stretch.sv
// One activity channel: a pulse lights the LED and holds it for STRETCH_TICKS ticks.
module act_stretch #(
    parameter int unsigned STRETCH_TICKS = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic act_i,
    input  logic tick_i,
    output logic led_o
);

    logic [7:0] sc_q, sc_d;
    logic       led_q;

    // A fresh pulse always reloads, so a tick on the same edge never shortens the stretch.
    always_comb begin
        sc_d = sc_q;
        if (act_i) begin
            sc_d = 8'(STRETCH_TICKS);
        end else if (tick_i && (sc_q != 8'd0)) begin
            sc_d = sc_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sc_q  <= 8'd0;
            led_q <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            led_q <= (sc_d != 8'd0);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_flow_indicator.sv
// Prescaled LED pattern generator with per-channel activity stretchers.
module led_flow_indicator
    import led_ind_pkg::*;
#(
    parameter int unsigned N_LED         = 6,
    parameter int unsigned DIV_W         = 22,
    parameter int unsigned ACT_CH        = 2,
    parameter int unsigned STRETCH_TICKS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  mode_t             mode,
    input  logic              dir,
    input  logic [ACT_CH-1:0] act,
    output logic [N_LED-1:0]  led_flow,
    output logic [ACT_CH-1:0] led_act,
    output logic              tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic [N_LED-1:0] flow_q, flow_d;
    logic [N_LED-1:0] step;
    logic [N_LED-1:0] seed;
    logic             tickInt;

    assign tickInt = en & (&cnt_q);

    always_comb begin
        step = flow_q;
        unique case (mode_q)
            JOHNSON: step = dir ? {~flow_q[0], flow_q[N_LED-1:1]}
                                : {flow_q[N_LED-2:0], ~flow_q[N_LED-1]};
            ROTATE:  step = dir ? {flow_q[0], flow_q[N_LED-1:1]}
                                : {flow_q[N_LED-2:0], flow_q[N_LED-1]};
            BLINK:   step = ~flow_q;
            BAR:     step = (&flow_q) ? '0 : {flow_q[N_LED-2:0], 1'b1};
        endcase
    end

    assign seed = (mode == ROTATE) ? ROTATE_SEED[N_LED-1:0] : '0;

    // A mode switch restarts the prescaler and pattern; it also overrides any step that edge.
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        flow_d = flow_q;
        if (mode != mode_q) begin
            mode_d = mode;
            cnt_d  = '0;
            flow_d = seed;
        end else begin
            if (en) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (tickInt) begin
                flow_d = step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q  <= '0;
            mode_q <= JOHNSON;
            flow_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            flow_q <= flow_d;
        end
    end

    for (genvar i = 0; i < ACT_CH; i++) begin : g_stretch
        act_stretch #(
            .STRETCH_TICKS(STRETCH_TICKS)
        ) u_stretch (
            .clk   (clk),
            .rstn  (rstn),
            .act_i (act[i]),
            .tick_i(tickInt),
            .led_o (led_act[i])
        );
    end

    assign led_flow = flow_q;
    assign tick     = tickInt;

endmodule

// File: tb/tb_led_flow_indicator.sv
// Bench for led_flow_indicator: fixed pattern table, corner sequences, random run vs model.
module tb_led_flow_indicator;
    import led_ind_pkg::*;

    localparam int N    = 6;
    localparam int DW   = 4;
    localparam int CH   = 2;
    localparam int ST   = 3;
    localparam int CMAX = (1 << DW) - 1;
    localparam int MASK = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    mode_t         mode;
    logic          dirIn;
    logic [CH-1:0] act;
    logic [N-1:0]  ledFlow;
    logic [CH-1:0] ledAct;
    logic          tick;

    always #5 clk = ~clk;

    led_flow_indicator #(
        .N_LED(N), .DIV_W(DW), .ACT_CH(CH), .STRETCH_TICKS(ST)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .mode    (mode),
        .dir     (dirIn),
        .act     (act),
        .led_flow(ledFlow),
        .led_act (ledAct),
        .tick    (tick)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: prescaler count, active mode, LED value, and per channel
    // how many ticks have elapsed since the last activity cycle.
    int mCnt;
    int mMode;
    int mLed;
    int mSince [CH];
    bit mSeen  [CH];

    function automatic int nextPattern(int md, bit d, int v);
        int lvl;
        case (md)
            0: return d ? ((v >> 1) | (((v & 1) != 0) ? 0 : (1 << (N - 1))))
                        : (((v << 1) & MASK) | ((((v >> (N - 1)) & 1) != 0) ? 0 : 1));
            1: return d ? ((v >> 1) | ((v & 1) << (N - 1)))
                        : (((v << 1) & MASK) | ((v >> (N - 1)) & 1));
            2: return (~v) & MASK;
            default: begin
                lvl = $countones(v);
                return (lvl >= N) ? 0 : ((1 << (lvl + 1)) - 1);
            end
        endcase
    endfunction

    task automatic modelEdge();
        bit tk;
        if (!rstn) begin
            mCnt = 0; mMode = 0; mLed = 0;
            for (int c = 0; c < CH; c++) begin
                mSeen[c] = 0; mSince[c] = 0;
            end
        end else begin
            tk = en && (mCnt == CMAX);
            if (int'(mode) != mMode) begin
                mMode = int'(mode);
                mCnt  = 0;
                mLed  = (mMode == 1) ? 1 : 0;
            end else begin
                if (en) mCnt = (mCnt + 1) % (CMAX + 1);
                if (tk) mLed = nextPattern(mMode, dirIn, mLed);
            end
            for (int c = 0; c < CH; c++) begin
                if (act[c]) begin
                    mSeen[c] = 1; mSince[c] = 0;
                end else if (tk && mSince[c] < ST) begin
                    mSince[c]++;
                end
            end
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("led_flow", int'(ledFlow), mLed);
        for (int c = 0; c < CH; c++)
            checkValue("led_act", int'(ledAct[c]), (mSeen[c] && mSince[c] < ST) ? 1 : 0);
        checkValue("tick", int'(tick), (en && mCnt == CMAX) ? 1 : 0);
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    typedef struct {
        mode_t md;
        bit    d;
        int    cycles;
        int    expLed;
        bit    expTick;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rstn = 1'b0; en = 1'b1; mode = JOHNSON; dirIn = 1'b0; act = '0;

        // Pattern walk: each entry runs a number of edges, then checks fixed values.
        tbl.push_back('{JOHNSON, 1'b0, 15, 'h00, 1'b1});
        tbl.push_back('{JOHNSON, 1'b0,  1, 'h01, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0, 16, 'h03, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0, 64, 'h3F, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0, 16, 'h3E, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0, 80, 'h00, 1'b0});
        tbl.push_back('{ROTATE,  1'b0,  1, 'h01, 1'b0});
        tbl.push_back('{ROTATE,  1'b0, 16, 'h02, 1'b0});
        tbl.push_back('{ROTATE,  1'b0, 80, 'h01, 1'b0});
        tbl.push_back('{ROTATE,  1'b1, 16, 'h20, 1'b0});
        tbl.push_back('{ROTATE,  1'b1, 16, 'h10, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0,  1, 'h00, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0, 32, 'h03, 1'b0});
        tbl.push_back('{JOHNSON, 1'b0,  5, 'h03, 1'b0});
        tbl.push_back('{BAR,     1'b0,  1, 'h00, 1'b0});
        tbl.push_back('{BAR,     1'b0, 15, 'h00, 1'b1});
        tbl.push_back('{BAR,     1'b0,  1, 'h01, 1'b0});
        tbl.push_back('{BAR,     1'b0, 80, 'h3F, 1'b0});
        tbl.push_back('{BAR,     1'b0, 16, 'h00, 1'b0});
        tbl.push_back('{BLINK,   1'b0,  1, 'h00, 1'b0});
        tbl.push_back('{BLINK,   1'b0, 16, 'h3F, 1'b0});
        tbl.push_back('{BLINK,   1'b0, 16, 'h00, 1'b0});

        #2;
        applyStimulus(1);
        checkValue("reset_led", int'(ledFlow), 0);
        checkValue("reset_act", int'(ledAct), 0);
        checkValue("reset_tick", int'(tick), 0);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            mode = tbl[i].md; dirIn = tbl[i].d;
            applyStimulus(tbl[i].cycles);
            checkValue("tbl_led", int'(ledFlow), tbl[i].expLed);
            checkValue("tbl_tick", int'(tick), int'(tbl[i].expTick));
        end

        // Single pulse stretch, then a pulse landing on a tick edge.
        rstn = 1'b0; mode = JOHNSON; dirIn = 1'b0;
        applyStimulus(1);
        rstn = 1'b1;
        act = 2'b01; applyStimulus(1); act = '0;
        checkValue("pulse_lit", int'(ledAct), 1);
        applyStimulus(46);
        checkValue("pulse_hold", int'(ledAct[0]), 1);
        applyStimulus(1);
        checkValue("pulse_off", int'(ledAct[0]), 0);
        applyStimulus(15);
        act = 2'b01; applyStimulus(1); act = '0;
        checkValue("tickpulse_lit", int'(ledAct), 1);
        applyStimulus(47);
        checkValue("tickpulse_hold", int'(ledAct[0]), 1);
        applyStimulus(1);
        checkValue("tickpulse_off", int'(ledAct[0]), 0);

        // Freeze during BLINK while a pulse arrives on channel 1.
        mode = BLINK; applyStimulus(1);
        applyStimulus(20);
        en = 1'b0;
        applyStimulus(5);
        act = 2'b10; applyStimulus(1); act = '0;
        applyStimulus(34);
        checkValue("frozen_led", int'(ledFlow), 'h3F);
        checkValue("frozen_act", int'(ledAct[1]), 1);
        en = 1'b1;
        applyStimulus(43);
        checkValue("thaw_act_hold", int'(ledAct[1]), 1);
        checkValue("thaw_led", int'(ledFlow), 'h3F);
        applyStimulus(1);
        checkValue("thaw_act_off", int'(ledAct[1]), 0);
        checkValue("thaw_led_step", int'(ledFlow), 'h00);

        // Reset in the middle of BAR with both activity LEDs lit.
        mode = BAR; applyStimulus(1);
        applyStimulus(47);
        act = 2'b11; applyStimulus(1); act = '0;
        checkValue("bar_pre_led", int'(ledFlow), 'h07);
        checkValue("bar_pre_act", int'(ledAct), 3);
        rstn = 1'b0; applyStimulus(1);
        checkValue("rst_led", int'(ledFlow), 0);
        checkValue("rst_act", int'(ledAct), 0);
        checkValue("rst_tick", int'(tick), 0);
        rstn = 1'b1; applyStimulus(1);
        applyStimulus(15);
        checkValue("reload_tick", int'(tick), 1);
        applyStimulus(81);
        checkValue("reload_bar_full", int'(ledFlow), 'h3F);
        applyStimulus(16);
        checkValue("reload_bar_wrap", int'(ledFlow), 'h00);

        // Random run against the reference model.
        for (int k = 0; k < 3000; k++) begin
            rstn = ($urandom_range(99) != 0);
            en   = ($urandom_range(9) < 8);
            if ($urandom_range(59) == 0) mode = mode_t'($urandom_range(3));
            if ($urandom_range(29) == 0) dirIn = ~dirIn;
            for (int c = 0; c < CH; c++) act[c] = ($urandom_range(15) == 0);
            applyStimulus(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_flow_indicator.md
LED_FLOW_INDICATOR -- requirements
Module: led_flow_indicator

Interface
REQ-001 Parameter N_LED, 6, pattern LED count; legal range 2..16.
REQ-002 Parameter DIV_W, 22, prescaler width; tick period is 2^DIV_W clk cycles; legal range 2..32.
REQ-003 Parameter ACT_CH, 2, number of activity-stretch channels; legal range 1..8.
REQ-004 Parameter STRETCH_TICKS, 4, ticks an activity LED stays lit after its last pulse; legal range 1..255.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  1 = prescaler runs; 0 = prescaler, pattern and stretch countdown frozen.
REQ-008 mode  in  2  pattern select, mode_t: JOHNSON=0, ROTATE=1, BLINK=2, BAR=3.
REQ-009 dir  in  1  0 = shift toward MSB, 1 = shift toward LSB; applies to JOHNSON and ROTATE only.
REQ-010 act  in  ACT_CH  per-channel activity pulses, synchronous to clk, level-sampled every cycle.
REQ-011 led_flow  out  N_LED  pattern output, registered.
REQ-012 led_act  out  ACT_CH  stretched activity output, registered.
REQ-013 tick  out  1  one-cycle strobe marking a pattern update edge.

Function
REQ-014 Prescaler cnt (DIV_W bits) increments by 1 each cycle en=1 and wraps 2^DIV_W-1 -> 0.
REQ-015 tick = en & (cnt == all-ones), combinational from registered cnt; pattern and stretch counters update on the edge where tick=1.
REQ-016 JOHNSON, dir=0: led_flow <= {led_flow[N-2:0], ~led_flow[N-1]}; dir=1: {~led_flow[0], led_flow[N-1:1]}; period 2*N_LED ticks.
REQ-017 ROTATE: one-hot rotate, dir=0 left (bit N-1 -> bit 0), dir=1 right; period N_LED ticks.
REQ-018 BLINK: led_flow <= ~led_flow each tick.
REQ-019 BAR: if led_flow all-ones, led_flow <= 0, else {led_flow[N-2:0], 1'b1}; period N_LED+1 ticks.
REQ-020 Registered mode_q tracks mode; when mode != mode_q, at that edge: mode_q <= mode, cnt <= 0, led_flow <= seed of new mode (ROTATE seed = 1 in bit 0, all others 0); no pattern step that edge even if tick=1.
REQ-021 dir change takes effect on the next tick with no reload.
REQ-022 Per channel i, 8-bit counter sc[i]: act[i]=1 loads STRETCH_TICKS (regardless of en); else tick=1 and sc[i]!=0 decrements; led_act[i] <= (next sc[i] != 0).
REQ-023 act[i]=1 coinciding with tick: load wins, no decrement that edge.
REQ-024 act[i] held high keeps led_act[i]=1 continuously; LED goes low exactly STRETCH_TICKS ticks after the last act cycle.
REQ-025 en=0: cnt, led_flow, mode_q hold; tick=0; act loads still accepted; mode changes still reload seed (REQ-020).

Reset
REQ-026 rstn=0 at a rising edge: cnt=0, mode_q=JOHNSON, led_flow=0, all sc=0, led_act=0; tick=0 the following cycle.
REQ-027 Reset mid-pattern discards all state; first tick after release occurs 2^DIV_W cycles after the first en=1 cycle.
REQ-028 mode_q resets to JOHNSON; if mode!=JOHNSON at release, REQ-020 reload occurs on the first edge after release.

Structure
REQ-029 Package led_ind_pkg holds typedef enum logic[1:0] mode_t and the ROTATE seed constant.
REQ-030 One sub-module act_stretch (one channel, params STRETCH_TICKS), instantiated ACT_CH times by generate.

Verification (DIV_W=4, N_LED=6, ACT_CH=2, STRETCH_TICKS=3)
REQ-031 Reset, en=1, JOHNSON dir=0 -> tick at cycles 15,31,...; led_flow 000001,000011,...,111111 (tick 6), 111110 (tick 7), 000000 at tick 12.
REQ-032 ROTATE dir=0 for 6 ticks then dir=1 -> 000010..100000,000001 then 100000 on next tick; no reload on dir change.
REQ-033 mode JOHNSON->BAR mid-count -> next edge led_flow=0, cnt=0, next tick at +16 cycles; BAR reaches 111111 at tick 6, 000000 at tick 7.
REQ-034 act[0] one-cycle pulse -> led_act[0]=1 next edge, low after 3rd subsequent tick; pulse on a tick edge -> no decrement that edge.
REQ-035 en=0 for 40 cycles mid-BLINK -> led_flow and cnt frozen, tick never asserts, act[1] pulse still lights led_act[1] and it stays lit until en=1 plus 3 ticks.
REQ-036 rstn=0 for 1 cycle during BAR=000111 with led_act=11 -> all outputs 0 next cycle; mode_q=JOHNSON then BAR reload on following edge.
